// File: rtl/calc_key_sequencer_if.sv
// Bundle of all non-clock/reset signals of calc_key_sequencer.
//   key_pulse/key_code          : decoded key-press strobe and 9-bit scan code {ext, byte}
//   alu_start/op/a/b            : one-cycle start request and operands to the arithmetic unit
//   alu_done/result/neg         : one-cycle result strobe, magnitude and sign
//   disp3..disp0                : display nibbles (0-9 digit, A minus, E error, F blank)
//   state/err                   : debug FSM state and timeout error flag
// modport master : the sequencer side; modport slave : keyboard/ALU/display side.
interface calc_key_sequencer_if #(
  parameter int unsigned RES_W = 14
) ();
  logic             key_pulse;
  logic [8:0]       key_code;
  logic             alu_start;
  logic [1:0]       alu_op;
  logic [6:0]       alu_a;
  logic [6:0]       alu_b;
  logic             alu_done;
  logic [RES_W-1:0] alu_result;
  logic             alu_neg;
  logic [3:0]       disp3;
  logic [3:0]       disp2;
  logic [3:0]       disp1;
  logic [3:0]       disp0;
  logic [2:0]       state;
  logic             err;

  modport master (
    input  key_pulse, key_code, alu_done, alu_result, alu_neg,
    output alu_start, alu_op, alu_a, alu_b, disp3, disp2, disp1, disp0, state, err
  );

  modport slave (
    output key_pulse, key_code, alu_done, alu_result, alu_neg,
    input  alu_start, alu_op, alu_a, alu_b, disp3, disp2, disp1, disp0, state, err
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Keypad calculator controller. Assembles two 2-digit decimal operands and an operator
// from key-press scan codes, runs one start/done transaction on the shared arithmetic unit,
// converts the binary result to BCD by sequential double-dabble and drives 4 display nibbles.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   io_bus : calc_key_sequencer_if.master (keys, ALU handshake, display, debug)
module calc_key_sequencer #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned RES_W   = 14
) (
  input logic                  clk,
  input logic                  rst_n,
  calc_key_sequencer_if.master io_bus
);

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CONV  = 3'd4,
    S_SHOW  = 3'd5
  } state_e;

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CntW = $clog2(RES_W);

  // Operand display: tens blank until two digits are in, ones shows 0 when empty.
  function automatic logic [15:0] opnd_disp(input logic [1:0] cnt, input logic [3:0] tens,
                                            input logic [3:0] ones);
    return {8'hFF, (cnt == 2'd2) ? tens : 4'hF, (cnt != 2'd0) ? ones : 4'h0};
  endfunction

  // Result display: blank leading zeros (digit 0 always shown), minus left of the MSD.
  function automatic logic [15:0] fmt_result(input logic [15:0] bcd, input logic neg);
    logic [3:0] d3, d2, d1, d0;
    d3 = bcd[15:12];
    d2 = bcd[11:8];
    d1 = bcd[7:4];
    d0 = bcd[3:0];
    if (d3 == 4'd0) begin
      d3 = 4'hF;
      if (d2 == 4'd0) begin
        d2 = 4'hF;
        if (d1 == 4'd0) d1 = 4'hF;
      end
    end
    if (neg) begin
      if (d1 == 4'hF)      d1 = 4'hA;
      else if (d2 == 4'hF) d2 = 4'hA;
      else if (d3 == 4'hF) d3 = 4'hA;
    end
    return {d3, d2, d1, d0};
  endfunction

  state_e           r_state, w_state_d;
  logic [3:0]       r_a_tens, w_a_tens_d, r_a_ones, w_a_ones_d;
  logic [3:0]       r_b_tens, w_b_tens_d, r_b_ones, w_b_ones_d;
  logic [1:0]       r_a_cnt, w_a_cnt_d, r_b_cnt, w_b_cnt_d;
  logic [1:0]       r_op, w_op_d, r_alu_op, w_alu_op_d;
  logic [6:0]       r_alu_a, w_alu_a_d, r_alu_b, w_alu_b_d;
  logic [TmoW-1:0]  r_tmo, w_tmo_d;
  logic [RES_W-1:0] r_bin, w_bin_d;
  logic [15:0]      r_bcd, w_bcd_d;
  logic             r_neg, w_neg_d;
  logic [CntW-1:0]  r_conv_cnt, w_conv_cnt_d;
  logic             r_err, w_err_d;
  logic [15:0]      r_disp, w_disp_d;

  // Key decode, qualified by key_pulse.
  logic       w_is_digit, w_is_op, w_enter, w_esc;
  logic [3:0] w_digit;
  logic [1:0] w_op;

  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    w_is_op    = 1'b0;
    w_op       = 2'd0;
    w_enter    = 1'b0;
    w_esc      = 1'b0;
    if (io_bus.key_pulse) begin
      case (io_bus.key_code)
        9'h070: begin w_is_digit = 1'b1; w_digit = 4'd0; end
        9'h069: begin w_is_digit = 1'b1; w_digit = 4'd1; end
        9'h072: begin w_is_digit = 1'b1; w_digit = 4'd2; end
        9'h07A: begin w_is_digit = 1'b1; w_digit = 4'd3; end
        9'h06B: begin w_is_digit = 1'b1; w_digit = 4'd4; end
        9'h073: begin w_is_digit = 1'b1; w_digit = 4'd5; end
        9'h074: begin w_is_digit = 1'b1; w_digit = 4'd6; end
        9'h06C: begin w_is_digit = 1'b1; w_digit = 4'd7; end
        9'h075: begin w_is_digit = 1'b1; w_digit = 4'd8; end
        9'h07D: begin w_is_digit = 1'b1; w_digit = 4'd9; end
        9'h079: begin w_is_op = 1'b1; w_op = 2'd0; end
        9'h07B: begin w_is_op = 1'b1; w_op = 2'd1; end
        9'h07C: begin w_is_op = 1'b1; w_op = 2'd2; end
        9'h05A: w_enter = 1'b1;
        9'h076: w_esc = 1'b1;
        default: ;
      endcase
    end
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift the next binary bit in.
  logic [15:0] w_bcd_adj, w_bcd_shift;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
    end
    w_bcd_shift = {w_bcd_adj[14:0], r_bin[RES_W-1]};
  end

  logic [6:0] w_val_a, w_val_b;
  assign w_val_a = {3'b000, r_a_tens} * 7'd10 + {3'b000, r_a_ones};
  assign w_val_b = {3'b000, r_b_tens} * 7'd10 + {3'b000, r_b_ones};

  always_comb begin
    w_state_d    = r_state;
    w_a_tens_d   = r_a_tens;
    w_a_ones_d   = r_a_ones;
    w_a_cnt_d    = r_a_cnt;
    w_b_tens_d   = r_b_tens;
    w_b_ones_d   = r_b_ones;
    w_b_cnt_d    = r_b_cnt;
    w_op_d       = r_op;
    w_alu_op_d   = r_alu_op;
    w_alu_a_d    = r_alu_a;
    w_alu_b_d    = r_alu_b;
    w_tmo_d      = r_tmo;
    w_bin_d      = r_bin;
    w_bcd_d      = r_bcd;
    w_neg_d      = r_neg;
    w_conv_cnt_d = r_conv_cnt;
    w_err_d      = r_err;
    w_disp_d     = r_disp;

    unique case (r_state)
      S_A: begin
        if (w_is_digit && r_a_cnt < 2'd2) begin
          w_a_tens_d = r_a_ones;
          w_a_ones_d = w_digit;
          w_a_cnt_d  = r_a_cnt + 2'd1;
          w_disp_d   = opnd_disp(r_a_cnt + 2'd1, r_a_ones, w_digit);
        end else if (w_is_op && r_a_cnt != 2'd0) begin
          w_op_d    = w_op;
          w_state_d = S_B;
          w_disp_d  = opnd_disp(r_b_cnt, r_b_tens, r_b_ones);
        end
      end
      S_B: begin
        if (w_is_digit && r_b_cnt < 2'd2) begin
          w_b_tens_d = r_b_ones;
          w_b_ones_d = w_digit;
          w_b_cnt_d  = r_b_cnt + 2'd1;
          w_disp_d   = opnd_disp(r_b_cnt + 2'd1, r_b_ones, w_digit);
        end else if (w_enter && r_b_cnt != 2'd0) begin
          // Operands are registered here so they are valid during the start cycle.
          w_alu_a_d  = w_val_a;
          w_alu_b_d  = w_val_b;
          w_alu_op_d = r_op;
          w_state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_tmo_d   = '0;
        w_state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.alu_done) begin
          w_bin_d      = io_bus.alu_result;
          w_neg_d      = io_bus.alu_neg;
          w_bcd_d      = '0;
          w_conv_cnt_d = '0;
          w_state_d    = S_CONV;
        end else if (r_tmo == TmoW'(TIMEOUT - 1)) begin
          w_err_d   = 1'b1;
          w_disp_d  = 16'hEEEE;
          w_state_d = S_SHOW;
        end else begin
          w_tmo_d = r_tmo + 1'b1;
        end
      end
      S_CONV: begin
        w_bcd_d      = w_bcd_shift;
        w_bin_d      = {r_bin[RES_W-2:0], 1'b0};
        w_conv_cnt_d = r_conv_cnt + 1'b1;
        if (r_conv_cnt == CntW'(RES_W - 1)) begin
          w_disp_d  = fmt_result(w_bcd_shift, r_neg);
          w_state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_is_digit) begin
          w_a_tens_d = 4'd0;
          w_a_ones_d = w_digit;
          w_a_cnt_d  = 2'd1;
          w_b_tens_d = 4'd0;
          w_b_ones_d = 4'd0;
          w_b_cnt_d  = 2'd0;
          w_err_d    = 1'b0;
          w_disp_d   = opnd_disp(2'd1, 4'd0, w_digit);
          w_state_d  = S_A;
        end
      end
      default: w_state_d = S_A;
    endcase

    // Esc behaves like a synchronous reset from any state.
    if (w_esc) begin
      w_state_d    = S_A;
      w_a_tens_d   = 4'd0;
      w_a_ones_d   = 4'd0;
      w_a_cnt_d    = 2'd0;
      w_b_tens_d   = 4'd0;
      w_b_ones_d   = 4'd0;
      w_b_cnt_d    = 2'd0;
      w_op_d       = 2'd0;
      w_alu_op_d   = 2'd0;
      w_alu_a_d    = 7'd0;
      w_alu_b_d    = 7'd0;
      w_tmo_d      = '0;
      w_bin_d      = '0;
      w_bcd_d      = '0;
      w_neg_d      = 1'b0;
      w_conv_cnt_d = '0;
      w_err_d      = 1'b0;
      w_disp_d     = 16'hFFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_A;
      r_a_tens   <= 4'd0;
      r_a_ones   <= 4'd0;
      r_a_cnt    <= 2'd0;
      r_b_tens   <= 4'd0;
      r_b_ones   <= 4'd0;
      r_b_cnt    <= 2'd0;
      r_op       <= 2'd0;
      r_alu_op   <= 2'd0;
      r_alu_a    <= 7'd0;
      r_alu_b    <= 7'd0;
      r_tmo      <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_conv_cnt <= '0;
      r_err      <= 1'b0;
      r_disp     <= 16'hFFFF;
    end else begin
      r_state    <= w_state_d;
      r_a_tens   <= w_a_tens_d;
      r_a_ones   <= w_a_ones_d;
      r_a_cnt    <= w_a_cnt_d;
      r_b_tens   <= w_b_tens_d;
      r_b_ones   <= w_b_ones_d;
      r_b_cnt    <= w_b_cnt_d;
      r_op       <= w_op_d;
      r_alu_op   <= w_alu_op_d;
      r_alu_a    <= w_alu_a_d;
      r_alu_b    <= w_alu_b_d;
      r_tmo      <= w_tmo_d;
      r_bin      <= w_bin_d;
      r_bcd      <= w_bcd_d;
      r_neg      <= w_neg_d;
      r_conv_cnt <= w_conv_cnt_d;
      r_err      <= w_err_d;
      r_disp     <= w_disp_d;
    end
  end

  assign io_bus.alu_start = (r_state == S_ISSUE);
  assign io_bus.alu_op    = r_alu_op;
  assign io_bus.alu_a     = r_alu_a;
  assign io_bus.alu_b     = r_alu_b;
  assign io_bus.disp3     = r_disp[15:12];
  assign io_bus.disp2     = r_disp[11:8];
  assign io_bus.disp1     = r_disp[7:4];
  assign io_bus.disp0     = r_disp[3:0];
  assign io_bus.state     = r_state;
  assign io_bus.err       = r_err;

endmodule
